mac_seq_ctrl: RTL and testbench

Sequencing and datapath front-end of the MAC unit, directly upstream of the 22-bit load-enabled accumulator register. Accepts a stream of unsigned 8-bit operand pairs over a valid/ready handshake, registers each product, and computes the next accumulator value. It drives the accumulator's `d`/`ld` inputs and reads back its `q`. It clears the accumulator at the start of every job, counts terms, flags overflow, and pulses `done` when the final sum is in the accumulator.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_seq_ctrl_if.sv | 10 +
 rtl/mac_mul_stage.sv | 27 ++
 rtl/mac_seq_ctrl.sv | 111 +++++++++++
 tb/tb_mac_seq_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared widths, accumulator limit and FSM state encoding for the MAC sequencer.
package mac_pkg;
    localparam int DW    = 8;
    localparam int AW    = 22;
    localparam int LEN_W = 7;

    localparam logic [AW-1:0] ACC_MAX = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Operand-pair valid/ready stream feeding the MAC sequencer.
interface mac_seq_ctrl_if #(parameter int DW = mac_pkg::DW);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;

    modport master (output in_valid, output a, output b, input in_ready);
    modport slave  (input in_valid, input a, input b, output in_ready);
endinterface

// File: rtl/mac_mul_stage.sv
// Product register: captures a*b on an accepted beat and flags it for the add stage.
module mac_mul_stage #(
    parameter int DW = mac_pkg::DW
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clr,
    input  logic            ld,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] p_r,
    output logic            p_v
);
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p_r <= '0;
            p_v <= 1'b0;
        end else if (clr) begin
            p_v <= 1'b0;
        end else if (ld) begin
            p_r <= a * b;
            p_v <= 1'b1;
        end else begin
            p_v <= 1'b0;
        end
    end
endmodule

// File: rtl/mac_seq_ctrl.sv
// MAC sequencer: job FSM, term counter and add stage driving an external accumulator.
// Build option MAC_SAT_EN: saturate the accumulator at its maximum instead of wrapping.
module mac_seq_ctrl #(
    parameter int DW    = mac_pkg::DW,
    parameter int AW    = mac_pkg::AW,
    parameter int LEN_W = mac_pkg::LEN_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    mac_seq_ctrl_if.slave    s,
    input  logic [AW-1:0]    acc_q,
    output logic [AW-1:0]    acc_d,
    output logic             acc_ld,
    output logic             busy,
    output logic             done,
    output logic             ovf
);
    import mac_pkg::*;

    state_t           state;
    logic [LEN_W-1:0] rem;
    logic             in_ready_r;
    logic             beat;
    logic             add_en;
    logic [2*DW-1:0]  p_r;
    logic             p_v;
    logic [AW:0]      sum;

    // Gate with reset so no beat is taken while reset is held.
    assign s.in_ready = in_ready_r & reset_n;
    assign beat       = s.in_valid & s.in_ready;
    assign add_en     = p_v & ((state == RUN) | (state == DRAIN));
    assign sum        = {1'b0, acc_q} + (AW+1)'(p_r);

    mac_mul_stage #(.DW(DW)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state == CLR),
        .ld      (beat),
        .a       (s.a),
        .b       (s.b),
        .p_r     (p_r),
        .p_v     (p_v)
    );

    always_comb begin
        acc_ld = 1'b0;
        acc_d  = '0;
        if (reset_n) begin
            if (state == CLR) begin
                acc_ld = 1'b1;
            end else if (add_en) begin
                acc_ld = 1'b1;
`ifdef MAC_SAT_EN
                acc_d  = sum[AW] ? AW'(ACC_MAX) : sum[AW-1:0];
`else
                acc_d  = sum[AW-1:0];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            rem        <= '0;
            in_ready_r <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (add_en && sum[AW])
                ovf <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    rem   <= len;
                    busy  <= 1'b1;
                    state <= CLR;
                end
                CLR: begin
                    ovf <= 1'b0;
                    if (rem == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        in_ready_r <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: if (beat) begin
                    rem <= rem - 1'b1;
                    if (rem == LEN_W'(1)) begin
                        in_ready_r <= 1'b0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural 22-bit load-enabled accumulator.
module tb_mac_seq_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  len = '0;
    logic [21:0] acc_q = 22'h2AAAAA;
    logic [21:0] acc_d;
    logic        acc_ld, busy, done, ovf;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];

    mac_seq_ctrl_if iv ();

    mac_seq_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .len     (len),
        .s       (iv),
        .acc_q   (acc_q),
        .acc_d   (acc_d),
        .acc_ld  (acc_ld),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (acc_ld) acc_q <= acc_d;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job from the queued pairs; dt is done cycle minus start cycle.
    task automatic job(input int n, input int gap, input bit hold, input bit poke,
                       output int dt, output int nb, output int nld, output bit irs,
                       output logic [21:0] qd);
        int i, g, t0;
        bit fin;
        i = 0; g = 0; fin = 0; dt = -1; nb = 0; nld = 0; irs = 0; qd = '0;
        start = 1'b1;
        len   = 7'(n);
        t0    = cyc;
        for (int c = 0; c < 1000 && !fin; c++) begin
            if (c > 0) begin
                start = poke && (i == 1);
                if (poke && i == 1) len = 7'd99;
            end
            if (i < qa.size() && g == 0) begin
                iv.in_valid = 1'b1;
                iv.a = qa[i];
                iv.b = qb[i];
            end else begin
                iv.in_valid = hold && (i >= qa.size());
            end
            @(negedge clk);
            if (iv.in_ready) irs = 1'b1;
            if (acc_ld) nld++;
            if (iv.in_valid && iv.in_ready) begin
                nb++;
                if (i < qa.size()) begin
                    i++;
                    g = gap;
                end
            end else if (g > 0) begin
                g--;
            end
            if (done) begin
                dt  = cyc - t0;
                qd  = acc_q;
                fin = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        if (hold) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (iv.in_valid && iv.in_ready) nb++;
                tick();
            end
        end
        iv.in_valid = 1'b0;
        chk("job_finished", fin, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int dt, nb, nld;
        bit irs;
        logic [21:0] qd;
        longint ovf_exp;

        iv.in_valid = 1'b0;
        iv.a = '0;
        iv.b = '0;
        tick(); tick();
        chk("rst_in_ready", iv.in_ready, 0);
        chk("rst_acc_ld", acc_ld, 0);
        chk("rst_acc_d", acc_d, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        reset_n = 1'b1;
        tick();

        // basic: 2+12+30+56
        qa = '{8'd1, 8'd3, 8'd5, 8'd7};
        qb = '{8'd2, 8'd4, 8'd6, 8'd8};
        job(4, 0, 0, 0, dt, nb, nld, irs, qd);
        chk("basic_sum", qd, 100);
        chk("basic_done_t", dt, 7);
        chk("basic_ovf", ovf, 0);
        chk("basic_beats", nb, 4);
        chk("basic_lds", nld, 5);

        // two idle cycles between beats add four cycles
        qa = '{8'd10, 8'd10, 8'd10};
        qb = '{8'd10, 8'd10, 8'd10};
        job(3, 2, 0, 0, dt, nb, nld, irs, qd);
        chk("stall_sum", qd, 300);
        chk("stall_done_t", dt, 10);
        chk("stall_lds", nld, 4);

        qa = {};
        qb = {};
        for (int k = 0; k < 127; k++) begin
            qa.push_back(8'd255);
            qb.push_back(8'd255);
        end
`ifdef MAC_SAT_EN
        ovf_exp = 64'h3FFFFF;
`else
        ovf_exp = (64'd127 * 64'd65025) % (64'd1 << 22);
`endif
        job(127, 0, 0, 0, dt, nb, nld, irs, qd);
        chk("ovf_flag", ovf, 1);
        chk("ovf_sum", qd, ovf_exp);
        chk("ovf_done_t", dt, 130);

        qa = {};
        qb = {};
        job(0, 0, 0, 0, dt, nb, nld, irs, qd);
        chk("len0_sum", qd, 0);
        chk("len0_done_t", dt, 2);
        chk("len0_ready_seen", irs, 0);
        chk("len0_ovf_cleared", ovf, 0);

        // reset after two beats of a five-term job
        start = 1'b1; len = 7'd5;
        tick();
        start = 1'b0;
        tick();
        iv.in_valid = 1'b1; iv.a = 8'd9; iv.b = 8'd9;
        tick(); tick();
        reset_n = 1'b0;
        tick();
        chk("mid_rst_in_ready", iv.in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_acc_ld", acc_ld, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ovf", ovf, 0);
        iv.in_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        qa = '{8'd2};
        qb = '{8'd3};
        job(1, 0, 0, 0, dt, nb, nld, irs, qd);
        chk("post_rst_sum", qd, 6);
        chk("post_rst_ovf", ovf, 0);
        chk("post_rst_done_t", dt, 4);

        // stray start during RUN and valid held through DONE/IDLE
        qa = '{8'd3, 8'd4};
        qb = '{8'd5, 8'd6};
        job(2, 0, 1, 1, dt, nb, nld, irs, qd);
        chk("poke_sum", qd, 39);
        chk("poke_beats", nb, 2);
        chk("poke_done_t", dt, 5);
        chk("poke_idle_busy", busy, 0);
        chk("poke_acc_hold", acc_q, 39);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
